uart_fifo_mmio: RTL and testbench

Parametrised memory-mapped UART peripheral with RX and TX FIFOs. It replaces the single-byte uart_rx/uart_tx pair behind the mmio decoder. The baud divisor, FIFO depth and data width are configurable, and the block adds sticky error flags and an interrupt output. It sits on the CPU data-memory bus next to data_src and drives the board rx/tx pins directly.

---
 rtl/uart_fifo_mmio.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_mmio.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_mmio.sv
// Memory-mapped UART with parameterised RX/TX FIFOs, programmable bit-period
// divisor, sticky error flags and a registered level interrupt.
module uart_fifo_mmio #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // Register decode; the two low address bits are don't-care.
    logic sel_data, sel_status, sel_ctrl;
    assign sel_data   = (addr[3:2] == REG_DATA);
    assign sel_status = (addr[3:2] == REG_STATUS);
    assign sel_ctrl   = (addr[3:2] == REG_CTRL);

    logic [15:0] divisor;
    logic        rx_irq_en, tx_irq_en;
    logic        rx_overrun, frame_err, tx_overflow;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW:0]          tx_wr_ptr, tx_rd_ptr, tx_count;
    logic                 tx_fifo_empty, tx_fifo_full, tx_push, tx_pop, tx_drop;

    assign tx_count      = tx_wr_ptr - tx_rd_ptr;
    assign tx_fifo_empty = (tx_count == '0);
    assign tx_fifo_full  = (tx_count == (AW+1)'(FIFO_DEPTH));
    assign tx_push       = we & sel_data & ~tx_fifo_full;
    assign tx_drop       = we & sel_data & tx_fifo_full;

    // TX FIFO pointer update.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
        end
    end

    // TX FIFO storage write.
    // NOTE: storage is not reset; which entries are valid is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= wdata[DATA_BITS-1:0];
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]          rx_wr_ptr, rx_rd_ptr, rx_count;
    logic                 rx_fifo_empty, rx_fifo_full, rx_push, rx_pop, rx_push_req;
    logic [DATA_BITS-1:0] rx_shift;

    assign rx_count      = rx_wr_ptr - rx_rd_ptr;
    assign rx_fifo_empty = (rx_count == '0);
    assign rx_fifo_full  = (rx_count == (AW+1)'(FIFO_DEPTH));
    assign rx_pop        = re & sel_data & ~rx_fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign rx_push       = rx_push_req & (~rx_fifo_full | rx_pop);

    // RX FIFO pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
        end
    end

    // RX FIFO storage write.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr[AW-1:0]] <= rx_shift;
    end

    // ---------------- TX serialiser ----------------
    uart_state_t          tx_state, tx_state_next;
    logic [15:0]          tx_timer, tx_timer_next, tx_div, tx_div_next;
    logic [BW-1:0]        tx_bit, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_next;
    logic                 tx_next, tx_bit_end;

    assign tx_bit_end = (tx_timer == tx_div - 16'd1);

    // TX next-state logic: each of START/DATA-bit/STOP lasts tx_div cycles.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        tx_state_next = tx_state;
        tx_timer_next = tx_timer + 16'd1;
        tx_div_next   = tx_div;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        tx_pop        = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_timer_next = '0;
                if (!tx_fifo_empty) begin
                    tx_pop        = 1'b1;
                    tx_div_next   = divisor;
                    tx_shift_next = tx_mem[tx_rd_ptr[AW-1:0]];
                    tx_state_next = S_START;
                end
            end
            S_START: if (tx_bit_end) begin
                tx_timer_next = '0;
                tx_bit_next   = '0;
                tx_state_next = S_DATA;
            end
            S_DATA: if (tx_bit_end) begin
                tx_timer_next = '0;
                tx_shift_next = tx_shift >> 1;
                if (tx_bit == BW'(DATA_BITS - 1)) tx_state_next = S_STOP;
                else                              tx_bit_next   = tx_bit + 1'b1;
            end
            S_STOP: if (tx_bit_end) begin
                tx_timer_next = '0;
                if (!tx_fifo_empty) begin
                    tx_pop        = 1'b1;
                    tx_div_next   = divisor;
                    tx_shift_next = tx_mem[tx_rd_ptr[AW-1:0]];
                    tx_state_next = S_START;
                end else begin
                    tx_state_next = S_IDLE;
                end
            end
            default: tx_state_next = S_IDLE;
        endcase
        // The pin is registered from the next state so it is glitch-free.
        tx_next = 1'b1;
        if (tx_state_next == S_START)     tx_next = 1'b0;
        else if (tx_state_next == S_DATA) tx_next = tx_shift_next[0];
    end

    // TX state register and registered serial output.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_timer <= '0;
            tx_div   <= 16'(DIV_RESET);
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_timer <= tx_timer_next;
            tx_div   <= tx_div_next;
            tx_bit   <= tx_bit_next;
            tx_shift <= tx_shift_next;
            tx       <= tx_next;
        end
    end

    // ---------------- RX deserialiser ----------------
    logic                 rx_meta, rx_sync, rx_prev;
    uart_state_t          rx_state, rx_state_next;
    logic [15:0]          rx_timer, rx_timer_next, rx_div, rx_div_next;
    logic [BW-1:0]        rx_bit, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift_next;
    logic                 rx_bit_end, frame_err_set;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_bit_end = (rx_timer == rx_div - 16'd1);

    // RX next-state logic: centre-sample each bit; only a fresh falling edge
    // starts a frame, so a line stuck low after a framing error stays ignored.
    always_comb begin
        rx_state_next = rx_state;
        rx_timer_next = rx_timer + 16'd1;
        rx_div_next   = rx_div;
        rx_bit_next   = rx_bit;
        rx_shift_next = rx_shift;
        rx_push_req   = 1'b0;
        frame_err_set = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_timer_next = '0;
                if (rx_prev && !rx_sync) begin
                    rx_div_next   = divisor;
                    rx_state_next = S_START;
                end
            end
            S_START: if (rx_timer == (rx_div >> 1) - 16'd1) begin
                rx_timer_next = '0;
                rx_bit_next   = '0;
                rx_state_next = rx_sync ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_bit_end) begin
                rx_timer_next = '0;
                rx_shift_next = {rx_sync, rx_shift[DATA_BITS-1:1]};
                if (rx_bit == BW'(DATA_BITS - 1)) rx_state_next = S_STOP;
                else                              rx_bit_next   = rx_bit + 1'b1;
            end
            S_STOP: if (rx_bit_end) begin
                rx_timer_next = '0;
                rx_state_next = S_IDLE;
                if (rx_sync) rx_push_req   = 1'b1;
                else         frame_err_set = 1'b1;
            end
            default: rx_state_next = S_IDLE;
        endcase
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= S_IDLE;
            rx_timer <= '0;
            rx_div   <= 16'(DIV_RESET);
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_next;
            rx_timer <= rx_timer_next;
            rx_div   <= rx_div_next;
            rx_bit   <= rx_bit_next;
            rx_shift <= rx_shift_next;
        end
    end

    // ---------------- Register file ----------------
    logic [31:0] status, read_value;
    logic        tx_busy;

    assign tx_busy = (tx_state != S_IDLE);
    assign status  = {8'd0, 8'(tx_count), 8'(rx_count),
                      tx_overflow, tx_busy, frame_err, rx_overrun,
                      tx_fifo_empty, tx_fifo_full, rx_fifo_full, ~rx_fifo_empty};

    // Read multiplexer; an empty RX FIFO reads as zero.
    always_comb begin
        read_value = '0;
        case (addr[3:2])
            REG_DATA:   if (!rx_fifo_empty) read_value = 32'(rx_mem[rx_rd_ptr[AW-1:0]]);
            REG_STATUS: read_value = status;
            REG_CTRL:   read_value = {14'd0, tx_irq_en, rx_irq_en, divisor};
            default:    read_value = '0;
        endcase
    end

    // CTRL writes, sticky flags (a new event wins over a W1C in the same cycle),
    // registered read data and registered interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            divisor     <= 16'(DIV_RESET);
            rx_irq_en   <= 1'b0;
            tx_irq_en   <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
            tx_overflow <= 1'b0;
            rdata       <= '0;
            irq         <= 1'b0;
        end else begin
            if (we && sel_ctrl) begin
                divisor   <= (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
                rx_irq_en <= wdata[16];
                tx_irq_en <= wdata[17];
            end
            if (rx_push_req && rx_fifo_full && !rx_pop) rx_overrun  <= 1'b1;
            else if (we && sel_status && wdata[4])      rx_overrun  <= 1'b0;
            if (frame_err_set)                          frame_err   <= 1'b1;
            else if (we && sel_status && wdata[5])      frame_err   <= 1'b0;
            if (tx_drop)                                tx_overflow <= 1'b1;
            else if (we && sel_status && wdata[7])      tx_overflow <= 1'b0;
            if (re) rdata <= read_value;
            irq <= (rx_irq_en & ~rx_fifo_empty) | (tx_irq_en & tx_fifo_empty)
                 | rx_overrun | frame_err;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wdata[31:18], addr[1:0]};

endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Directed testbench for uart_fifo_mmio: TX framing, RX capture, FIFO limits,
// sticky flags, interrupt and mid-frame reset.
module tb_uart_fifo_mmio;
    localparam int          DIV      = 8;
    localparam logic [3:0]  A_DATA   = 4'h0;
    localparam logic [3:0]  A_STATUS = 4'h4;
    localparam logic [3:0]  A_CTRL   = 4'h8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        we, re;
    logic [31:0] rdata;
    logic        rx, tx, irq;

    int checks = 0;
    int errors = 0;

    uart_fifo_mmio #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_RESET(868)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .rx(rx), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        d = rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Returns at the first negedge where tx is low, or reports a timeout.
    task automatic wait_tx_start(input string tag);
        int found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    logic [31:0] rd;
    logic [7:0]  pattern;

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_rdata", rdata, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        bus_read(A_CTRL, rd);
        check("reset_ctrl", rd, 32'd868);
        bus_read(A_STATUS, rd);
        check("reset_status", rd, 32'h0000_0008);

        // 1: transmit 0xA5 at divisor 8
        bus_write(A_CTRL, 32'd8);
        bus_write(A_DATA, 32'h0000_00A5);
        wait_tx_start("t1_start_seen");      // offset 0.5 into start bit
        bus_read(A_STATUS, rd);              // offset 2.5
        check("t1_busy_early", rd[6], 1'b1);
        @(negedge clk);                      // offset 3.5
        check("t1_start_bit", 32'(tx), 32'd0);
        pattern = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            repeat (DIV) @(negedge clk);     // offset 11.5 + 8k
            check("t1_data_bit", 32'(tx), 32'(pattern[k]));
        end
        repeat (DIV) @(negedge clk);         // offset 75.5
        check("t1_stop_bit", 32'(tx), 32'd1);
        repeat (3) @(negedge clk);           // offset 78.5
        bus_read(A_STATUS, rd);              // captured at edge 80, still STOP
        check("t1_busy_last_cycle", rd[6], 1'b1);
        bus_read(A_STATUS, rd);
        check("t1_status_idle", rd, 32'h0000_0008);

        // 2: receive 0x3C
        send_rx(8'h3C, 1'b1);
        bus_read(A_STATUS, rd);
        check("t2_status", rd, 32'h0000_0109);
        check("t2_irq_off", 32'(irq), 32'd0);
        bus_read(A_DATA, rd);
        check("t2_data", rd, 32'h0000_003C);
        bus_read(A_DATA, rd);
        check("t2_data_empty", rd, 32'd0);

        // 3: TX FIFO full and overflow
        for (int i = 0; i < 17; i++) bus_write(A_DATA, 32'(8'h40 + i));
        bus_read(A_STATUS, rd);
        check("t3_full", rd, 32'h0010_0044);
        bus_write(A_DATA, 32'h0000_00EE);
        bus_read(A_STATUS, rd);
        check("t3_overflow", rd, 32'h0010_00C4);
        bus_write(A_STATUS, 32'h0000_0080);
        bus_read(A_STATUS, rd);
        check("t3_overflow_clear", rd, 32'h0010_0044);

        // 4: RX overrun
        do_reset();
        bus_write(A_CTRL, 32'd8);
        for (int i = 0; i < 17; i++) send_rx(8'(8'h10 + i), 1'b1);
        bus_read(A_STATUS, rd);
        check("t4_status", rd, 32'h0000_101B);
        check("t4_irq", 32'(irq), 32'd1);
        for (int i = 0; i < 16; i++) begin
            bus_read(A_DATA, rd);
            check("t4_data", rd, 32'(8'h10 + i));
        end
        bus_read(A_STATUS, rd);
        check("t4_drained", rd, 32'h0000_0018);
        bus_write(A_STATUS, 32'h0000_0010);
        repeat (2) @(negedge clk);
        check("t4_irq_clear", 32'(irq), 32'd0);

        // 5: framing error, then a short glitch
        send_rx(8'h55, 1'b0);
        bus_read(A_STATUS, rd);
        check("t5_frame_err", rd, 32'h0000_0028);
        check("t5_irq", 32'(irq), 32'd1);
        bus_write(A_STATUS, 32'h0000_0020);
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        bus_read(A_STATUS, rd);
        check("t5_glitch", rd, 32'h0000_0008);

        // CTRL clamp, read-back and tx interrupt enable
        bus_write(A_CTRL, 32'd2);
        bus_read(A_CTRL, rd);
        check("ctrl_clamp", rd, 32'd4);
        bus_write(A_CTRL, 32'hFFFF_0010);
        bus_read(A_CTRL, rd);
        check("ctrl_readback", rd, 32'h0003_0010);
        check("ctrl_tx_irq", 32'(irq), 32'd1);
        bus_write(A_CTRL, 32'd8);
        repeat (2) @(negedge clk);
        check("ctrl_irq_off", 32'(irq), 32'd0);

        // 6: reset in the middle of a data bit
        bus_write(A_DATA, 32'h0000_0000);
        wait_tx_start("t6_start_seen");      // offset 0.5
        bus_write(A_DATA, 32'h0000_0000);    // offset 2.5, second byte queued
        repeat (18) @(negedge clk);          // offset 20.5, data bit 1
        check("t6_data_low", 32'(tx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_tx_after_rst", 32'(tx), 32'd1);
        bus_read(A_STATUS, rd);
        check("t6_status", rd, 32'h0000_0008);
        bus_read(A_CTRL, rd);
        check("t6_div_reset", rd, 32'd868);
        repeat (20) @(negedge clk);
        check("t6_tx_idle", 32'(tx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
